sensor_cond: RTL and testbench

Upstream conditioning stage for the PID drive loop. Samples motor current and crank torque on the A2D ready strobe and smooths each with a 4-tap exponential average. Measures cadence as rising edges per fixed window and flags not-pedaling. Produces the signed 13-bit `error` (target current minus average current) and `not_pedaling` consumed directly by the PID stage.

---
 rtl/sensor_cond_if.sv | 25 ++
 rtl/sensor_cond.sv | 106 ++++++++++
 tb/tb_sensor_cond.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sensor_cond_if.sv
// Sensor conditioning bus: raw A2D samples and crank level in, smoothed
// values, cadence measurement and the PID error term out.
interface sensor_cond_if;
  logic        cur_rdy;
  logic [11:0] curr;
  logic [11:0] torque;
  logic        cadence;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;
  logic [4:0]  cadence_rate;
  logic        not_pedaling;
  logic [12:0] error;

  // Producer of samples and consumer of conditioned results.
  modport master (
    output cur_rdy, curr, torque, cadence,
    input  avg_curr, avg_torque, cadence_rate, not_pedaling, error
  );

  // The conditioning block itself.
  modport slave (
    input  cur_rdy, curr, torque, cadence,
    output avg_curr, avg_torque, cadence_rate, not_pedaling, error
  );
endinterface

// File: rtl/sensor_cond.sv
// Upstream conditioning for the PID drive loop: exponential averaging of
// current and torque, cadence rate over a fixed window, and the signed
// current error (target minus average) with a pedaling gate.
module sensor_cond #(
  parameter bit          FAST_SIM = 1'b0,
  parameter logic [11:0] TQ_MIN   = 12'd380
) (
  input  logic         clk,
  input  logic         rst,
  sensor_cond_if.slave bus
);

  localparam int WIN_W = FAST_SIM ? 12 : 24;

  logic [13:0]      acc_curr;
  logic [13:0]      acc_torque;
  logic             cadence_prev;
  logic             rise;
  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  logic [4:0]       edge_cnt;
  logic [4:0]       edge_cnt_inc;
  logic [4:0]       rate_q;
  logic             not_pedaling;
  logic [11:0]      avg_curr;
  logic [11:0]      avg_torque;
  logic [11:0]      tq_excess;
  logic [11:0]      target_curr;
  logic [12:0]      error_d;
  logic [12:0]      error_q;

  // Leaky 4-tap averagers: acc settles at 4x a constant input, so the
  // averaged value is simply the top 12 bits. 4*4095 fits in 14 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_curr   <= '0;
      acc_torque <= '0;
    end else if (bus.cur_rdy) begin
      acc_curr   <= acc_curr - (acc_curr >> 2) + {2'b00, bus.curr};
      acc_torque <= acc_torque - (acc_torque >> 2) + {2'b00, bus.torque};
    end
  end

  assign avg_curr   = acc_curr[13:2];
  assign avg_torque = acc_torque[13:2];

  // Previous cadence level for rising-edge detection; resets low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cadence_prev <= 1'b0;
    else     cadence_prev <= bus.cadence;
  end

  assign rise    = bus.cadence & ~cadence_prev;
  assign win_end = &win_cnt;

  // Free-running measurement window; terminal count marks the window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_cnt <= '0;
    else     win_cnt <= win_cnt + 1'b1;
  end

  // Edge count including a rise on this cycle, held at 31.
  always_comb begin
    edge_cnt_inc = edge_cnt;
    if (rise && (edge_cnt != 5'd31)) edge_cnt_inc = edge_cnt + 5'd1;
  end

  // Count rises within the window; publish and restart at the window end.
  // A rise landing on the window-end cycle belongs to the closing window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      rate_q   <= '0;
    end else if (win_end) begin
      edge_cnt <= '0;
      rate_q   <= edge_cnt_inc;
    end else begin
      edge_cnt <= edge_cnt_inc;
    end
  end

  assign not_pedaling = (rate_q < 5'd2);

  // Torque above the dead-band becomes the current target while pedaling.
  always_comb begin
    tq_excess   = 12'd0;
    target_curr = 12'd0;
    if (avg_torque > TQ_MIN) tq_excess = avg_torque - TQ_MIN;
    if (!not_pedaling) target_curr = tq_excess;
    error_d = {1'b0, target_curr} - {1'b0, avg_curr};
  end

  // Error is re-registered every cycle so pedaling changes reach the PID
  // stage without waiting for the next sample strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= '0;
    else     error_q <= error_d;
  end

  assign bus.avg_curr     = avg_curr;
  assign bus.avg_torque   = avg_torque;
  assign bus.cadence_rate = rate_q;
  assign bus.not_pedaling = not_pedaling;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_sensor_cond.sv
// Directed bench for sensor_cond with the short cadence window.
module tb_sensor_cond;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  sensor_cond_if bus ();

  sensor_cond #(.FAST_SIM(1'b1), .TQ_MIN(12'd380)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic strobe();
    bus.cur_rdy = 1'b1;
    @(negedge clk);
    bus.cur_rdy = 1'b0;
  endtask

  // Spends exactly one window (4096 edges) producing n rises early on.
  task automatic run_window(input int n);
    for (int i = 0; i < 4096; i++) begin
      bus.cadence = (i < 8 * n) && ((i % 8) >= 4);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_avg_curr"},   32'(bus.avg_curr),     32'd0);
    chk({tag, "_avg_torque"}, 32'(bus.avg_torque),   32'd0);
    chk({tag, "_rate"},       32'(bus.cadence_rate), 32'd0);
    chk({tag, "_not_ped"},    32'(bus.not_pedaling), 32'd1);
    chk({tag, "_error"},      32'(bus.error),        32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    bus.cur_rdy = 1'b0;
    bus.curr    = 12'd0;
    bus.torque  = 12'd0;
    bus.cadence = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b0;

    // Single steps from empty accumulator: 400 -> 100, then acc 700 -> 175.
    bus.curr = 12'd400;
    strobe();
    chk("step1_avg", 32'(bus.avg_curr), 32'd100);
    strobe();
    chk("step2_avg", 32'(bus.avg_curr), 32'd175);
    @(negedge clk);
    chk("step2_err", 32'(bus.error), 32'h1F51);

    // Settle on 1000 with no torque; not pedaling so target is 0.
    bus.curr   = 12'd1000;
    bus.torque = 12'd0;
    repeat (40) strobe();
    chk("avg1000_avg", 32'(bus.avg_curr), 32'd1000);
    chk("avg1000_tq",  32'(bus.avg_torque), 32'd0);
    chk("avg1000_np",  32'(bus.not_pedaling), 32'd1);
    @(negedge clk);
    chk("avg1000_err", 32'(bus.error), 32'h1C18);

    // Mid-run asynchronous reset, checked before any clock edge.
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;

    // Cadence windows aligned to reset release.
    run_window(40);
    chk("win40_rate", 32'(bus.cadence_rate), 32'd31);
    chk("win40_np",   32'(bus.not_pedaling), 32'd0);
    run_window(1);
    chk("win1_rate",  32'(bus.cadence_rate), 32'd1);
    chk("win1_np",    32'(bus.not_pedaling), 32'd1);
    run_window(5);
    chk("win5_rate",  32'(bus.cadence_rate), 32'd5);
    chk("win5_np",    32'(bus.not_pedaling), 32'd0);

    // Pedaling (rate 5 holds through this window): target path.
    bus.curr   = 12'd200;
    bus.torque = 12'd1380;
    repeat (60) strobe();
    @(negedge clk);
    chk("tgt_avg_tq",   32'(bus.avg_torque), 32'd1380);
    chk("tgt_avg_curr", 32'(bus.avg_curr),   32'd200);
    chk("tgt_err",      32'(bus.error),      32'd800);

    bus.torque = 12'd300;
    repeat (60) strobe();
    @(negedge clk);
    chk("deadband_tq",  32'(bus.avg_torque), 32'd300);
    chk("deadband_err", 32'(bus.error),      32'h1F38);

    bus.torque = 12'd4095;
    bus.curr   = 12'd0;
    repeat (80) strobe();
    @(negedge clk);
    chk("max_tq_avg", 32'(bus.avg_torque), 32'd4095);
    chk("max_tq_err", 32'(bus.error),      32'd3715);

    bus.torque = 12'd0;
    bus.curr   = 12'd4095;
    repeat (80) strobe();
    @(negedge clk);
    chk("max_cur_avg", 32'(bus.avg_curr), 32'd4095);
    chk("max_cur_err", 32'(bus.error),    32'h1001);
    chk("still_ped",   32'(bus.not_pedaling), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
